// File: rtl/uart_echo_responder_if.sv
// Byte-level handshake between the UART receiver/transmitter pair and the echo responder.
// The responder takes the slave side; whatever drives the UART link takes the master side.
interface uart_echo_responder_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [7:0]       i_rx_data;
  logic             i_rx_done;
  logic             i_tx_done;
  logic             i_clr_err;
  logic             o_start;
  logic [7:0]       o_tx_data;
  logic             o_busy;
  logic [CNT_W-1:0] o_count;
  logic             o_overflow;
  logic             o_timeout;

  modport slave (
    input  i_rx_data, i_rx_done, i_tx_done, i_clr_err,
    output o_start, o_tx_data, o_busy, o_count, o_overflow, o_timeout
  );

  modport master (
    output i_rx_data, i_rx_done, i_tx_done, i_clr_err,
    input  o_start, o_tx_data, o_busy, o_count, o_overflow, o_timeout
  );
endinterface

// File: rtl/uart_echo_responder.sv
// Echoes every byte completed by the UART receiver back through the transmitter.
// Received bytes queue in a small FIFO; a watchdog frees the FSM if i_tx_done never arrives.
module uart_echo_responder #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_echo_responder_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             overflow_q, overflow_d;
  logic             timeout_q, timeout_d;

  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic push;
  logic overflow_set;
  logic timeout_set;

  assign fifo_full    = (count_q == CNT_W'(DEPTH));
  assign fifo_empty   = (count_q == '0);
  assign pop          = (state_q == IDLE) && !fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push         = bus.i_rx_done && (!fifo_full || pop);
  assign overflow_set = bus.i_rx_done && fifo_full && !pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.i_rx_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    wd_d        = wd_q;
    timeout_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          tx_data_d = mem_q[rd_ptr_q];
          state_d   = START;
        end
      end
      START: begin
        wd_d    = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.i_tx_done) begin
          state_d = IDLE;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_set = 1'b1;
          state_d     = IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sticky flags: a new event in the same cycle as a clear keeps the flag set.
  always_comb begin
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    if (bus.i_clr_err) begin
      overflow_d = 1'b0;
      timeout_d  = 1'b0;
    end
    if (overflow_set) begin
      overflow_d = 1'b1;
    end
    if (timeout_set) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      wd_q       <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      wd_q       <= wd_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.o_start    = (state_q == START);
  assign bus.o_busy     = (state_q == START) || (state_q == WAIT_DONE);
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_count    = count_q;
  assign bus.o_overflow = overflow_q;
  assign bus.o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_echo_responder.sv
// Scoreboard bench for uart_echo_responder: stimulus queues expected echoes,
// a negedge monitor pops them whenever the responder raises o_start.
module tb_uart_echo_responder;

  localparam int DEPTH = 4;
  localparam int TO    = 60;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] exp_q [$];
  logic [7:0] inflight;
  bit         inflight_valid = 1'b0;

  uart_echo_responder_if #(.DEPTH(DEPTH)) bus ();

  uart_echo_responder #(
    .DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input bit accept);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    if (accept) exp_q.push_back(b);
    tick();
    bus.i_rx_done = 1'b0;
  endtask

  task automatic end_tx();
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (!bus.o_start && n < budget) begin
      tick();
      n++;
    end
    check_output("start_seen", 32'(bus.o_start), 32'h1);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_start"},    32'(bus.o_start),    32'h0);
    check_output({tag, "_tx_data"},  32'(bus.o_tx_data),  32'h0);
    check_output({tag, "_busy"},     32'(bus.o_busy),     32'h0);
    check_output({tag, "_count"},    32'(bus.o_count),    32'h0);
    check_output({tag, "_overflow"}, 32'(bus.o_overflow), 32'h0);
    check_output({tag, "_timeout"},  32'(bus.o_timeout),  32'h0);
  endtask

  // Monitor: every o_start must carry the oldest outstanding byte, which then holds until the next start.
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (reset) begin
        inflight_valid = 1'b0;
      end else if (bus.o_start) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_start actual=0x%0h expected=no_start at %0t", bus.o_tx_data, $time);
        end else begin
          exp_b = exp_q.pop_front();
          check_output("echo_byte", 32'(bus.o_tx_data), 32'(exp_b));
          inflight       = exp_b;
          inflight_valid = 1'b1;
        end
      end else if (inflight_valid) begin
        check_output("tx_data_hold", 32'(bus.o_tx_data), 32'(inflight));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    logic [7:0] echoed;
    int starts;

    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    bus.i_clr_err = 1'b0;

    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_all_zero("reset");

    $display("[TB] single byte latency");
    apply_stimulus(8'h01, 1'b1);
    check_output("t1_start_c1", 32'(bus.o_start), 32'h0);
    check_output("t1_count_c1", 32'(bus.o_count), 32'h1);
    tick();
    check_output("t1_start_c2", 32'(bus.o_start), 32'h1);
    check_output("t1_data_c2",  32'(bus.o_tx_data), 32'h01);
    check_output("t1_busy_c2",  32'(bus.o_busy), 32'h1);
    check_output("t1_count_c2", 32'(bus.o_count), 32'h0);
    repeat (50) tick();
    check_output("t1_busy_wait", 32'(bus.o_busy), 32'h1);
    end_tx();
    check_output("t1_busy_after", 32'(bus.o_busy), 32'h0);

    $display("[TB] loopback transmitter");
    apply_stimulus(8'hAA, 1'b1);
    wait_start(10);
    echoed = bus.o_tx_data;
    repeat (10) tick();
    end_tx();
    check_output("t2_loopback", 32'(echoed), 32'hAA);
    check_output("t2_busy_after", 32'(bus.o_busy), 32'h0);
    check_output("t2_data_after", 32'(bus.o_tx_data), 32'hAA);

    $display("[TB] fill and overflow");
    apply_stimulus(8'h0F, 1'b1);
    wait_start(10);
    tick();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(8'(32'h10 + i), 1'b1);
      check_output("t3_count_fill", 32'(bus.o_count), 32'(i + 1));
    end
    check_output("t3_overflow_pre", 32'(bus.o_overflow), 32'h0);
    apply_stimulus(8'h14, 1'b0);
    check_output("t3_count_full", 32'(bus.o_count), 32'h4);
    check_output("t3_overflow", 32'(bus.o_overflow), 32'h1);
    end_tx();
    check_output("t3_gap_start", 32'(bus.o_start), 32'h0);
    check_output("t3_gap_busy",  32'(bus.o_busy), 32'h0);
    tick();
    check_output("t3_next_start", 32'(bus.o_start), 32'h1);
    for (int k = 0; k < 4; k++) begin
      repeat (5) tick();
      end_tx();
      check_output("t3_gap_start", 32'(bus.o_start), 32'h0);
      tick();
      check_output("t3_next_start", 32'(bus.o_start), (k < 3) ? 32'h1 : 32'h0);
    end
    check_output("t3_count_empty", 32'(bus.o_count), 32'h0);
    bus.i_clr_err = 1'b1;
    tick();
    bus.i_clr_err = 1'b0;
    check_output("t3_overflow_clr", 32'(bus.o_overflow), 32'h0);

    $display("[TB] push coincident with pop on full fifo");
    apply_stimulus(8'h20, 1'b1);
    wait_start(10);
    tick();
    for (int i = 1; i <= 4; i++) apply_stimulus(8'(32'h20 + i), 1'b1);
    check_output("t4_count_full", 32'(bus.o_count), 32'h4);
    end_tx();
    apply_stimulus(8'h25, 1'b1);
    check_output("t4_start", 32'(bus.o_start), 32'h1);
    check_output("t4_count", 32'(bus.o_count), 32'h4);
    check_output("t4_overflow", 32'(bus.o_overflow), 32'h0);
    for (int k = 0; k < 5; k++) begin
      repeat (3) tick();
      end_tx();
      tick();
      check_output("t4_drain_start", 32'(bus.o_start), (k < 4) ? 32'h1 : 32'h0);
    end
    check_output("t4_count_empty", 32'(bus.o_count), 32'h0);

    $display("[TB] watchdog");
    apply_stimulus(8'h30, 1'b1);
    apply_stimulus(8'h31, 1'b1);
    check_output("t5_start", 32'(bus.o_start), 32'h1);
    repeat (TO - 1) tick();
    check_output("t5_timeout_pre", 32'(bus.o_timeout), 32'h0);
    check_output("t5_busy_pre", 32'(bus.o_busy), 32'h1);
    repeat (2) tick();
    check_output("t5_timeout", 32'(bus.o_timeout), 32'h1);
    check_output("t5_idle", 32'(bus.o_busy), 32'h0);
    tick();
    check_output("t5_next_start", 32'(bus.o_start), 32'h1);
    bus.i_clr_err = 1'b1;
    tick();
    bus.i_clr_err = 1'b0;
    check_output("t5_timeout_clr", 32'(bus.o_timeout), 32'h0);
    end_tx();
    check_output("t5_busy_after", 32'(bus.o_busy), 32'h0);

    $display("[TB] reset during transmit");
    apply_stimulus(8'h40, 1'b1);
    wait_start(10);
    tick();
    apply_stimulus(8'h41, 1'b1);
    apply_stimulus(8'h42, 1'b1);
    check_output("t6_count_queued", 32'(bus.o_count), 32'h2);
    reset = 1'b1;
    exp_q.delete();
    tick();
    check_all_zero("t6_reset");
    reset = 1'b0;
    starts = 0;
    repeat (10) begin
      tick();
      if (bus.o_start) starts++;
    end
    check_output("t6_no_start", 32'(starts), 32'h0);
    apply_stimulus(8'h50, 1'b1);
    tick();
    check_output("t6_new_start", 32'(bus.o_start), 32'h1);
    check_output("t6_new_data", 32'(bus.o_tx_data), 32'h50);
    repeat (3) tick();
    end_tx();

    repeat (3) tick();
    check_output("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
